fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction fetch stage. Owns the PC, drives the async instruction memory's byte address,
//   and registers {pc, inst} into the IF/ID pipeline register toward decode using a valid/ready handshake.
//   Handles branch/jump redirects, decode back-pressure and halt.
//   Sits directly upstream of imem (address side) and decode (instruction side).
// PARAMETERS
//   ADDR_WIDTH  16   byte-address width of PC / imem_addr; PC wraps mod 2^ADDR_WIDTH
//   DATA_WIDTH  32   instruction width
//   RESET_PC    0    PC value loaded on reset; must be word-aligned
// PORTS
//   clk            in   1           rising-edge clock
//   rst_n          in   1           asynchronous, active-low reset
//   imem_addr      out  ADDR_WIDTH  byte address to imem; always equal to pc_q
//   imem_inst      in   DATA_WIDTH  instruction from imem, valid in the same cycle (async read)
//   redirect_valid in   1           redirect PC this cycle (taken branch/jump from EX)
//   redirect_pc    in   ADDR_WIDTH  redirect target byte address
//   halt           in   1           stop issuing new fetches while high
//   out_valid      out  1           IF/ID holds a valid instruction
//   out_ready      in   1           decode accepts IF/ID this cycle
//   out_pc         out  ADDR_WIDTH  PC of out_inst
//   out_inst       out  DATA_WIDTH  fetched instruction
//   misalign_err   out  1           1-cycle pulse: redirect_pc[1:0] != 0 was accepted
//   fetch_count    out  32          number of handshakes completed (out_valid & out_ready)
// BEHAVIOUR
//   Reset (async, rst_n=0): pc_q=RESET_PC, out_valid=0, out_pc=0, out_inst=NOP_INST,
//     misalign_err=0, fetch_count=0. Values hold until the first rising edge after deassertion.
//   Latency: instruction at pc_q appears on out_inst one cycle later (registered IF/ID). Throughput: 1/clk.
//   Let adv = !halt & (!out_valid | out_ready). Per-edge priority:
//     1. redirect_valid: pc_q <= {redirect_pc[AW-1:2],2'b00}. out_valid <= 0 (kills wrong-path inst).
//        out_pc/out_inst hold. This case applies regardless of out_ready or halt.
//        misalign_err <= |redirect_pc[1:0].
//     2. else adv: out_valid <= 1; out_pc <= pc_q; out_inst <= imem_inst; pc_q <= pc_q + 4.
//     3. else if out_ready (halted, slot drained): out_valid <= 0; pc_q holds.
//     4. else (stall: out_valid & !out_ready): all state holds.
//   misalign_err is 0 in every cycle in which case 1 does not apply.
//   Handshake: out_pc/out_inst must not change while out_valid & !out_ready, except when case 1 drops valid.
//   fetch_count: +1 on each edge where out_valid & out_ready (sampled pre-edge), including the edge a redirect
//     lands. Wraps at 2^32.
//   Wrap-around: pc_q = 2^AW-4 advances to 0; no error flagged.
//   Redirect + stall in the same cycle: the redirect wins and the stalled slot is discarded (decode must not
//     consume it).
//   Redirect while halted: pc_q updates; fetch resumes from the new PC when halt drops.
//   Reset mid-operation: async clear to the reset values above; any in-flight IF/ID content is lost.
// STRUCTURE
//   Shared package (cpu_pkg): NOP_INST, INST_BYTES=4, PC_ALIGN_BITS=2, default RESET_PC.
//   Sub-module fetch_pipe_reg: valid/ready holding register (valid, pc, inst), with a load and kill interface.
//     Reused for the later ID/EX stage.
//   Top level: PC register + next-PC mux (redirect / +4 / hold), misalign flag, fetch counter.
// TESTING (bench pairs this block with imem; program.hex word n = 32'hA000_0000+n)
//   1. Reset release, out_ready=1, halt=0 -> imem_addr 0,4,8...; after edge k, out_valid=1,
//      out_pc=4(k-1), out_inst=A000_0000+(k-1).
//   2. Hold out_ready=0 for 3 cycles with out_valid=1 -> out_pc/out_inst/imem_addr frozen; out_ready=1 then
//      resumes with no skipped or duplicated PCs. fetch_count advances by 1 per handshake only.
//   3. redirect_valid=1, redirect_pc=0x0040 while stalled -> next cycle out_valid=0, imem_addr=0x40;
//      the following cycle out_pc=0x40, out_inst=A000_0010.
//   4. redirect_pc=0x0043 -> misalign_err pulses for 1 cycle; pc_q=0x0040.
//   5. Redirect to 0xFFF8 with AW=16 -> out_pc 0xFFF8, 0xFFFC, 0x0000 in consecutive cycles.
//   6. halt=1 with slot full and out_ready=1 -> out_valid falls next cycle, PC holds.
//      Assert rst_n=0 mid-stream -> outputs at reset values immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction encoding constants and PC alignment.
package cpu_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam int unsigned INST_BYTES       = 4;
    localparam int unsigned PC_ALIGN_BITS    = 2;
    localparam int unsigned DEFAULT_RESET_PC = 0;

endpackage

// File: rtl/fetch_pipe_reg.sv
// Valid/ready pipeline holding register carrying {pc, inst}.
// kill drops valid and keeps the payload; load captures a new payload and sets valid.
// kill takes priority over load; with neither asserted all state holds.
module fetch_pipe_reg
    import cpu_pkg::*;
#(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          kill,
    input  logic [AW-1:0] in_pc,
    input  logic [DW-1:0] in_inst,
    output logic          valid,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] inst
);

    logic          valid_q;
    logic [AW-1:0] pc_q;
    logic [DW-1:0] inst_q;

    // Holding register: kill > load > hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            inst_q  <= DW'(NOP_INST);
        end else if (kill) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            pc_q    <= in_pc;
            inst_q  <= in_inst;
        end
    end

    assign valid = valid_q;
    assign pc    = pc_q;
    assign inst  = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection (redirect / +4 / hold),
// IF/ID register toward decode, misaligned-redirect flag and handshake counter.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned RESET_PC   = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_inst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    input  logic                  halt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic                  misalign_err,
    output logic [31:0]           fetch_count
);

    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] redirect_aligned;
    logic                  adv;
    logic                  load;
    logic                  kill;
    logic                  misalign_q;
    logic [31:0]           fetch_count_q;

    assign redirect_aligned = {redirect_pc[ADDR_WIDTH-1:PC_ALIGN_BITS], {PC_ALIGN_BITS{1'b0}}};

    // Advance when not halted and the IF/ID slot is empty or being consumed
    assign adv  = !halt && (!out_valid || out_ready);
    assign load = !redirect_valid && adv;
    // Redirect discards the wrong-path slot; a halted stage lets a consumed slot drain
    assign kill = redirect_valid || (halt && out_ready);

    // Next-PC mux: redirect wins, then sequential advance, else hold
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_aligned;
        end else if (adv) begin
            pc_d = pc_q + ADDR_WIDTH'(INST_BYTES);
        end
    end

    // PC, misalign pulse and handshake counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= ADDR_WIDTH'(RESET_PC);
            misalign_q    <= 1'b0;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            misalign_q    <= redirect_valid && (|redirect_pc[PC_ALIGN_BITS-1:0]);
            if (out_valid && out_ready) begin
                fetch_count_q <= fetch_count_q + 32'd1;
            end
        end
    end

    fetch_pipe_reg #(
        .AW (ADDR_WIDTH),
        .DW (DATA_WIDTH)
    ) u_if_id (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .kill    (kill),
        .in_pc   (pc_q),
        .in_inst (imem_inst),
        .valid   (out_valid),
        .pc      (out_pc),
        .inst    (out_inst)
    );

    assign imem_addr    = pc_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage paired with a combinational imem whose
// word n holds 32'hA000_0000 + n.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic [31:0] imem_inst;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [31:0] out_inst;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int checks;
    int errors;

    // Reference model state
    logic [15:0] m_pc;
    logic        m_valid;
    logic [15:0] m_out_pc;
    logic [31:0] m_out_inst;
    logic        m_err;
    logic [31:0] m_count;

    fetch_stage #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .RESET_PC   (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_inst       (out_inst),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] byte_addr);
        return 32'hA000_0000 + (32'(byte_addr) / 4);
    endfunction

    assign imem_inst = mem_word(imem_addr);

    task automatic model_reset();
        m_pc = 16'h0; m_valid = 1'b0; m_out_pc = 16'h0; m_out_inst = NOP;
        m_err = 1'b0; m_count = 32'h0;
    endtask

    // Apply inputs for one cycle, advance the model at the edge, settle 1ns after
    task automatic tick(input logic rv, input logic [15:0] rpc, input logic h, input logic rdy);
        redirect_valid = rv; redirect_pc = rpc; halt = h; out_ready = rdy;
        @(posedge clk);
        if (m_valid && rdy) m_count = m_count + 1;
        if (rv) begin
            m_pc    = rpc & 16'hFFFC;
            m_valid = 1'b0;
            m_err   = (rpc % 4) != 0;
        end else begin
            m_err = 1'b0;
            if (!h && (!m_valid || rdy)) begin
                m_valid    = 1'b1;
                m_out_pc   = m_pc;
                m_out_inst = mem_word(m_pc);
                m_pc       = m_pc + 16'd4;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; out_ready = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({imem_addr, out_valid, out_pc, out_inst, misalign_err, fetch_count} !==
            {16'h0, 1'b0, 16'h0, NOP, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset: addr=%h v=%b pc=%h inst=%h err=%b cnt=%0d required 0000/0/0000/%h/0/0",
                     imem_addr, out_valid, out_pc, out_inst, misalign_err, fetch_count, NOP);
        end
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        for (int k = 1; k <= 6; k++) begin
            tick(1'b0, 16'h0, 1'b0, 1'b1);
            checks++;
            if ({out_valid, out_pc, out_inst, imem_addr} !==
                {1'b1, 16'(4 * (k - 1)), 32'hA000_0000 + 32'(k - 1), 16'(4 * k)}) begin
                errors++;
                $display("FAIL seq k=%0d: v=%b pc=%h inst=%h addr=%h required 1/%h/%h/%h", k,
                         out_valid, out_pc, out_inst, imem_addr, 16'(4 * (k - 1)),
                         32'hA000_0000 + 32'(k - 1), 16'(4 * k));
            end
        end
        checks++;
        if (fetch_count !== 32'd5) begin
            errors++;
            $display("FAIL seq_count: got %0d required 5", fetch_count);
        end
    endtask

    task automatic test_stall();
        logic [15:0] s_pc, s_addr;
        logic [31:0] s_inst, s_cnt;
        s_pc = out_pc; s_inst = out_inst; s_addr = imem_addr; s_cnt = fetch_count;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0, 1'b0, 1'b0);
            checks++;
            if ({out_valid, out_pc, out_inst, imem_addr, fetch_count} !==
                {1'b1, s_pc, s_inst, s_addr, s_cnt}) begin
                errors++;
                $display("FAIL stall_hold i=%0d: v=%b pc=%h inst=%h addr=%h cnt=%0d required 1/%h/%h/%h/%0d",
                         i, out_valid, out_pc, out_inst, imem_addr, fetch_count,
                         s_pc, s_inst, s_addr, s_cnt);
            end
        end
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out_pc, out_inst, fetch_count} !==
            {1'b1, s_pc + 16'd4, mem_word(s_pc + 16'd4), s_cnt + 32'd1}) begin
            errors++;
            $display("FAIL stall_resume: v=%b pc=%h inst=%h cnt=%0d required 1/%h/%h/%0d",
                     out_valid, out_pc, out_inst, fetch_count, s_pc + 16'd4,
                     mem_word(s_pc + 16'd4), s_cnt + 32'd1);
        end
    endtask

    task automatic test_redirect_stall();
        logic [31:0] s_cnt;
        tick(1'b0, 16'h0, 1'b0, 1'b0);
        s_cnt = fetch_count;
        tick(1'b1, 16'h0040, 1'b0, 1'b0);
        checks++;
        if ({out_valid, imem_addr, fetch_count, misalign_err} !== {1'b0, 16'h0040, s_cnt, 1'b0}) begin
            errors++;
            $display("FAIL redir_stall: v=%b addr=%h cnt=%0d err=%b required 0/0040/%0d/0",
                     out_valid, imem_addr, fetch_count, misalign_err, s_cnt);
        end
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 16'h0040, 32'hA000_0010}) begin
            errors++;
            $display("FAIL redir_target: v=%b pc=%h inst=%h required 1/0040/a0000010",
                     out_valid, out_pc, out_inst);
        end
    endtask

    task automatic test_misalign();
        tick(1'b1, 16'h0043, 1'b0, 1'b1);
        checks++;
        if ({misalign_err, imem_addr, out_valid} !== {1'b1, 16'h0040, 1'b0}) begin
            errors++;
            $display("FAIL misalign_pulse: err=%b addr=%h v=%b required 1/0040/0",
                     misalign_err, imem_addr, out_valid);
        end
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if ({misalign_err, out_pc} !== {1'b0, 16'h0040}) begin
            errors++;
            $display("FAIL misalign_clear: err=%b pc=%h required 0/0040", misalign_err, out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] exp_pc [3];
        exp_pc[0] = 16'hFFF8; exp_pc[1] = 16'hFFFC; exp_pc[2] = 16'h0000;
        tick(1'b1, 16'hFFF8, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 16'h0, 1'b0, 1'b1);
            checks++;
            if ({out_valid, out_pc, out_inst, misalign_err} !==
                {1'b1, exp_pc[i], mem_word(exp_pc[i]), 1'b0}) begin
                errors++;
                $display("FAIL wrap i=%0d: v=%b pc=%h inst=%h err=%b required 1/%h/%h/0", i,
                         out_valid, out_pc, out_inst, misalign_err, exp_pc[i], mem_word(exp_pc[i]));
            end
        end
    endtask

    task automatic test_halt();
        logic [15:0] s_addr;
        s_addr = imem_addr;
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 16'h0, 1'b1, 1'b1);
            checks++;
            if ({out_valid, imem_addr} !== {1'b0, s_addr}) begin
                errors++;
                $display("FAIL halt i=%0d: v=%b addr=%h required 0/%h", i, out_valid, imem_addr, s_addr);
            end
        end
        tick(1'b1, 16'h0100, 1'b1, 1'b1);
        tick(1'b0, 16'h0, 1'b1, 1'b1);
        checks++;
        if ({out_valid, imem_addr} !== {1'b0, 16'h0100}) begin
            errors++;
            $display("FAIL halt_redirect: v=%b addr=%h required 0/0100", out_valid, imem_addr);
        end
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out_pc, out_inst} !== {1'b1, 16'h0100, mem_word(16'h0100)}) begin
            errors++;
            $display("FAIL halt_resume: v=%b pc=%h inst=%h required 1/0100/%h",
                     out_valid, out_pc, out_inst, mem_word(16'h0100));
        end
    endtask

    task automatic test_random();
        logic        rv, h, rdy, p_valid, p_rdy, p_rv;
        logic [15:0] rpc, p_pc;
        logic [31:0] p_inst;
        for (int i = 0; i < 400; i++) begin
            p_valid = out_valid; p_pc = out_pc; p_inst = out_inst;
            rv  = ($urandom_range(0, 7) == 0);
            rpc = 16'($urandom);
            h   = ($urandom_range(0, 5) == 0);
            rdy = ($urandom_range(0, 9) < 7);
            p_rdy = rdy; p_rv = rv;
            tick(rv, rpc, h, rdy);
            checks++;
            if ({imem_addr, out_valid, out_pc, out_inst, misalign_err, fetch_count} !==
                {m_pc, m_valid, m_out_pc, m_out_inst, m_err, m_count}) begin
                errors++;
                $display("FAIL random i=%0d: addr=%h v=%b pc=%h inst=%h err=%b cnt=%0d required %h/%b/%h/%h/%b/%0d",
                         i, imem_addr, out_valid, out_pc, out_inst, misalign_err, fetch_count,
                         m_pc, m_valid, m_out_pc, m_out_inst, m_err, m_count);
            end
            // A stalled slot keeps its payload and stays valid unless a redirect killed it
            if (p_valid && !p_rdy && !p_rv) begin
                checks++;
                if ({out_valid, out_pc, out_inst} !== {1'b1, p_pc, p_inst}) begin
                    errors++;
                    $display("FAIL stall_stable i=%0d: v=%b pc=%h inst=%h required 1/%h/%h",
                             i, out_valid, out_pc, out_inst, p_pc, p_inst);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        tick(1'b1, 16'h0203, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({imem_addr, out_valid, out_pc, out_inst, misalign_err, fetch_count} !==
            {16'h0, 1'b0, 16'h0, NOP, 1'b0, 32'h0}) begin
            errors++;
            $display("FAIL reset_mid: addr=%h v=%b pc=%h inst=%h err=%b cnt=%0d required 0000/0/0000/%h/0/0",
                     imem_addr, out_valid, out_pc, out_inst, misalign_err, fetch_count, NOP);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1'b0, 16'h0, 1'b0, 1'b1);
        checks++;
        if ({out_valid, out_pc, out_inst, imem_addr} !== {1'b1, 16'h0, 32'hA000_0000, 16'h4}) begin
            errors++;
            $display("FAIL reset_mid_restart: v=%b pc=%h inst=%h addr=%h required 1/0000/a0000000/0004",
                     out_valid, out_pc, out_inst, imem_addr);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        test_halt();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
